// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring radix-2 division, one quotient bit per cycle, MSB first.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_start,
    input  logic [2:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [4:0]      rd_in,
    output logic            div_stall,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t          state;
    logic [4:0]      count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvsr;
    logic [XLEN-1:0] rem;
    logic            q_neg;
    logic            r_neg;
    logic            op_is_rem;
    logic [4:0]      rd_q;

    logic            accept;
    logic            is_signed;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] dividend_mag;
    logic [XLEN-1:0] divisor_mag;
    logic [XLEN:0]   trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] final_result;

    // Request decode, operand magnitudes and the fast-path conditions seen in IDLE.
    always_comb begin
        accept       = div_start & div_op[2];
        is_signed    = ~div_op[0];
        div_zero     = (divisor == '0);
        overflow     = is_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);
        dividend_mag = (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
        divisor_mag  = (is_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
        div_stall    = ((state == IDLE) && accept) || (state == CALC);
    end

    // One restoring step plus the sign-corrected result used on the last step.
    always_comb begin
        trial        = {rem, quo[XLEN-1]} - {1'b0, dvsr};
        trial_ok     = ~trial[XLEN];
        rem_next     = trial_ok ? trial[XLEN-1:0] : {rem[XLEN-2:0], quo[XLEN-1]};
        quo_next     = {quo[XLEN-2:0], trial_ok};
        q_fix        = q_neg ? (~quo_next + 1'b1) : quo_next;
        r_fix        = r_neg ? (~rem_next + 1'b1) : rem_next;
        final_result = op_is_rem ? r_fix : q_fix;
    end

    // Control FSM with the datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            quo        <= '0;
            dvsr       <= '0;
            rem        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            op_is_rem  <= 1'b0;
            rd_q       <= '0;
            div_busy   <= 1'b0;
            div_done   <= 1'b0;
            div_result <= '0;
            rd_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_done <= 1'b0;
                    if (accept) begin
                        op_is_rem <= div_op[1];
                        rd_q      <= rd_in;
                        q_neg     <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        r_neg     <= is_signed & dividend[XLEN-1];
                        quo       <= dividend_mag;
                        dvsr      <= divisor_mag;
                        if (div_zero) begin
                            div_result <= div_op[1] ? dividend : ALL_ONES;
                            rd_out     <= rd_in;
                            div_done   <= 1'b1;
                            state      <= DONE;
                        end else if (overflow) begin
                            div_result <= div_op[1] ? '0 : MIN_NEG;
                            rd_out     <= rd_in;
                            div_done   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            rem      <= '0;
                            count    <= '0;
                            div_busy <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        div_result <= final_result;
                        rd_out     <= rd_q;
                        div_busy   <= 1'b0;
                        div_done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    div_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit, checked every cycle against an
// arithmetic reference model of result, latency, stall, busy and done.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic [2:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_in;
    logic        div_stall;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;
    logic [4:0]  rd_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          calc_lo    = 1;
    int          calc_hi    = 0;
    int          exp_done   = -1;
    int          free_cycle = 0;
    logic [31:0] exp_res    = '0;
    logic [31:0] last_res   = '0;
    logic [4:0]  exp_rd     = '0;
    logic [4:0]  last_rd    = '0;
    bit          enable     = 1'b0;

    div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_op     (div_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .rd_in      (rd_in),
        .div_stall  (div_stall),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result),
        .rd_out     (rd_out)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // RISC-V M-extension result rules written with plain arithmetic.
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit model_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    // Reference model: tracks accepted requests and when each one must complete.
    always @(posedge clk) begin : model
        int lat;
        if (rst) begin
            enable = 1'b1;
            if (calc_hi > cyc) calc_hi = cyc;
            if (exp_done > cyc) exp_done = -1;
            free_cycle = cyc + 1;
            last_res   = '0;
            last_rd    = '0;
        end else if (cyc >= free_cycle && div_start && div_op[2]) begin
            lat        = model_fast(div_op, dividend, divisor) ? 1 : 33;
            calc_lo    = cyc + 1;
            calc_hi    = cyc + lat - 1;
            exp_done   = cyc + lat;
            free_cycle = cyc + lat + 1;
            exp_res    = model_result(div_op, dividend, divisor);
            exp_rd     = rd_in;
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : compare
        bit exp_stall;
        bit exp_busy;
        bit exp_dn;
        if (enable) begin
            exp_busy  = (cyc >= calc_lo) && (cyc <= calc_hi);
            exp_stall = ((cyc >= free_cycle) && div_start && div_op[2]) || exp_busy;
            exp_dn    = (cyc == exp_done);
            checkOutput("div_stall", {31'b0, div_stall}, {31'b0, exp_stall});
            checkOutput("div_busy", {31'b0, div_busy}, {31'b0, exp_busy});
            checkOutput("div_done", {31'b0, div_done}, {31'b0, exp_dn});
            if (exp_dn) begin
                last_res = exp_res;
                last_rd  = exp_rd;
            end
            checkOutput("div_result", div_result, last_res);
            checkOutput("rd_out", {27'b0, rd_out}, {27'b0, last_rd});
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, output int t);
        @(posedge clk);
        #1;
        div_start = 1'b1;
        div_op    = op;
        dividend  = a;
        divisor   = b;
        rd_in     = rd;
        t         = cyc;
    endtask

    task automatic waitDone(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (div_done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit, input int lat);
        int t;
        int dc;
        applyStimulus(op, a, b, rd, t);
        @(posedge clk);
        #1;
        div_start = 1'b0;
        waitDone(40, dc);
        checkOutput({name, " latency"}, 32'(dc - t), 32'(lat));
        checkOutput({name, " result"}, div_result, lit);
        checkOutput({name, " rd"}, {27'b0, rd_out}, {27'b0, rd});
    endtask

    initial begin : stimulus
        int t;
        int dc;
        rst       = 1'b1;
        div_start = 1'b0;
        div_op    = 3'b000;
        dividend  = '0;
        divisor   = '0;
        rd_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset result", div_result, 32'h0);
        checkOutput("reset rd", {27'b0, rd_out}, 32'h0);
        checkOutput("reset done", {31'b0, div_done}, 32'h0);
        checkOutput("reset busy", {31'b0, div_busy}, 32'h0);

        checkOutput("model divu", model_result(3'b101, 32'd100, 32'd7), 32'd14);
        checkOutput("model rem neg", model_result(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        checkOutput("model div neg", model_result(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        checkOutput("model div0", model_result(3'b100, 32'd1234, 32'd0), 32'hFFFF_FFFF);
        checkOutput("model remu0", model_result(3'b111, 32'd1234, 32'd0), 32'd1234);
        checkOutput("model ovf div", model_result(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        checkOutput("model ovf rem", model_result(3'b110, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

        runOp("divu 100/7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        runOp("rem -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 33);
        runOp("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33);
        runOp("div 1234/0", 3'b100, 32'd1234, 32'd0, 5'd6, 32'hFFFF_FFFF, 1);
        runOp("remu 1234/0", 3'b111, 32'd1234, 32'd0, 5'd8, 32'd1234, 1);
        runOp("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        runOp("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0, 1);
        runOp("divu big", 3'b101, 32'hFFFF_FFFF, 32'h10, 5'd12, 32'h0FFF_FFFF, 33);
        runOp("remu big", 3'b111, 32'hFFFF_FFFF, 32'h10, 5'd13, 32'hF, 33);
        runOp("div -100/7", 3'b100, 32'hFFFF_FF9C, 32'd7, 5'd14, 32'hFFFF_FFF2, 33);
        runOp("rem 100%-7", 3'b110, 32'd100, 32'hFFFF_FFF9, 5'd15, 32'd2, 33);
        runOp("div minneg/2", 3'b100, 32'h8000_0000, 32'd2, 5'd31, 32'hC000_0000, 33);

        // Abort a DIVU with reset partway through the iteration.
        applyStimulus(3'b101, 32'd1000, 32'd3, 5'd9, t);
        @(posedge clk);
        #1;
        div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort cycle", 32'(cyc - t), 32'd11);
        checkOutput("abort busy", {31'b0, div_busy}, 32'h0);
        checkOutput("abort stall", {31'b0, div_stall}, 32'h0);
        checkOutput("abort result", div_result, 32'h0);
        waitDone(40, dc);
        checkOutput("abort no done", 32'(dc), 32'hFFFF_FFFF);

        // Hold div_start through DONE: the second accept follows immediately.
        applyStimulus(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd7, t);
        waitDone(40, dc);
        checkOutput("hold latency", 32'(dc - t), 32'd33);
        checkOutput("hold result", div_result, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("hold reaccept stall", {31'b0, div_stall}, 32'h1);
        @(posedge clk);
        #1;
        div_start = 1'b0;
        @(negedge clk);
        checkOutput("hold reaccept busy", {31'b0, div_busy}, 32'h1);
        waitDone(40, dc);
        checkOutput("hold second done", 32'(dc - t), 32'd67);

        // A non-M opcode must neither stall nor complete.
        applyStimulus(3'b011, 32'd10, 32'd2, 5'd1, t);
        @(negedge clk);
        checkOutput("invalid stall", {31'b0, div_stall}, 32'h0);
        waitDone(10, dc);
        checkOutput("invalid no done", 32'(dc), 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        div_start = 1'b0;

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divide/remainder unit that executes the operation requested by the decoder's `div_start` / `div_op` / `is_div_instruction` outputs. It sits in the execute stage beside the ALU. It takes rs1/rs2 operand values and the destination register tag, and stalls the pipeline while it iterates. It returns a single-cycle completion pulse carrying the result and tag for register write-back.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  system clock; everything is rising-edge.
- `rst`  in  1  reset; synchronous and active-high.
- `div_start`  in  1  request from the decoder; sampled only in IDLE.
- `div_op`  in  3  operation: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Encodings with bit 2 = 0 are invalid.
- `dividend`  in  32  rs1 value.
- `divisor`  in  32  rs2 value.
- `rd_in`  in  5  destination register tag.
- `div_stall`  out  1  combinational: `(state==IDLE & div_start & div_op[2]) | (state==CALC)`.
- `div_busy`  out  1  registered; high in CALC.
- `div_done`  out  1  registered; one-cycle pulse in DONE.
- `div_result`  out  32  quotient or remainder; valid while `div_done` is high and held afterwards.
- `rd_out`  out  5  latched `rd_in`; valid with `div_done`.

## Operation
States: IDLE, CALC, DONE.

- **IDLE**
  - A request is accepted when `div_start & div_op[2]` is high at an edge.
  - On accept, latch `div_op`, `rd_in`, and both operands.
  - Signed ops (op[0]=0): store operand magnitudes, plus `q_neg = dividend[31]^divisor[31]` and `r_neg = dividend[31]`.
  - Unsigned ops: store operands as-is; `q_neg = r_neg = 0`.
  - Fast path, divisor == 0: go to DONE. Result is 0xFFFFFFFF for DIV/DIVU, or the unmodified dividend for REM/REMU.
  - Fast path, signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): go to DONE. Result is 0x80000000 for DIV, 0 for REM.
  - Otherwise clear the 32-bit remainder accumulator, set count = 0, go to CALC.
  - `div_start` with `div_op[2]=0` is ignored: stay in IDLE, no stall.
- **CALC** (radix-2 restoring division, one quotient bit per cycle, MSB first)
  - Each cycle form a 33-bit trial value: `{rem, q[31]} - {0, divisor}`.
  - If the trial is non-negative: `rem` = trial[31:0] and the shifted-in quotient bit is 1.
  - Otherwise: `rem = {rem[30:0], q[31]}` and the shifted-in quotient bit is 0.
  - Shift the quotient register left by one each cycle; the dividend register doubles as the quotient register.
  - At count == 31, apply the sign fix and register the result, then go to DONE.
    - Quotient: negated if `q_neg`.
    - Remainder: negated if `r_neg`.
    - Select the quotient for op[1]=0, the remainder for op[1]=1.
  - `div_start` is ignored in CALC.
- **DONE**
  - `div_done` = 1 for exactly one cycle, then return to IDLE.
  - `div_start` is ignored in DONE. The pipeline advances during this cycle because `div_stall` = 0.
- Arithmetic: negation is two's complement, mod 2^32. Magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- Reset (any state, including mid-CALC): state = IDLE, count = 0, and all outputs are 0.
  - `div_stall` is 0 unless the IDLE accept condition holds.
  - An aborted operation never produces `div_done`.

## Timing
- Accept edge at cycle T.
- Normal path: CALC runs for cycles T+1..T+32; `div_done` is high in cycle T+33. Latency is 33 cycles.
- Fast paths: `div_done` is high in cycle T+1.
- `div_stall` is high from the request cycle T through the last CALC cycle, and low in DONE.
- Back-to-back: a new request may be accepted in the first IDLE cycle after DONE. There are no idle bubbles beyond that one cycle.
- `div_result` and `rd_out` keep their last values until the next DONE.

## Test plan
- DIVU 100 / 7, rd=5 → `div_done` at T+33, `div_result`=14, `rd_out`=5; `div_stall` high for T..T+32.
- REM −7 (0xFFFFFFF9) % 2 → 0xFFFFFFFF. DIV of the same operands → 0xFFFFFFFD (−3).
- DIV 1234 / 0 → 0xFFFFFFFF at T+1. REMU 1234 / 0 → 1234 at T+1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1. REM of the same operands → 0.
- Assert `rst` at T+10 of a DIVU → IDLE at T+11, and no `div_done` within 40 cycles.
- Hold `div_start` high with DIVU 0xFFFFFFFF / 1 across DONE → `div_done` fires once at T+33, result 0xFFFFFFFF. The next accept occurs at T+34. A start with `div_op`=011 yields no stall and no done.
